// File: rtl/ccis_fiu_mem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ccis_fiu_mem_responder_if: CCI-S wire bundle between an AFU-side adapter (master) and the FIU (slave).
// Revision 1.0
interface ccis_fiu_mem_responder_if;
  logic         ffs_vl_LP32ui_lp2sy_SoftReset_n;
  logic         ffs_vl_LP32ui_lp2sy_InitDnForSys;
  logic [60:0]  ffs_vl61_LP32ui_sy2lp_C0TxHdr;
  logic         ffs_vl_LP32ui_sy2lp_C0TxRdValid;
  logic [60:0]  ffs_vl61_LP32ui_sy2lp_C1TxHdr;
  logic [511:0] ffs_vl512_LP32ui_sy2lp_C1TxData;
  logic         ffs_vl_LP32ui_sy2lp_C1TxWrValid;
  logic         ffs_vl_LP32ui_sy2lp_C1TxIrValid;
  logic         ffs_vl_LP32ui_lp2sy_C0TxAlmFull;
  logic         ffs_vl_LP32ui_lp2sy_C1TxAlmFull;
  logic [17:0]  ffs_vl18_LP32ui_lp2sy_C0RxHdr;
  logic [511:0] ffs_vl512_LP32ui_lp2sy_C0RxData;
  logic         ffs_vl_LP32ui_lp2sy_C0RxRdValid;
  logic         ffs_vl_LP32ui_lp2sy_C0RxWrValid;
  logic         ffs_vl_LP32ui_lp2sy_C0RxCgValid;
  logic         ffs_vl_LP32ui_lp2sy_C0RxUgValid;
  logic         ffs_vl_LP32ui_lp2sy_C0RxIrValid;
  logic [17:0]  ffs_vl18_LP32ui_lp2sy_C1RxHdr;
  logic         ffs_vl_LP32ui_lp2sy_C1RxWrValid;
  logic         ffs_vl_LP32ui_lp2sy_C1RxIrValid;
  logic         overflow_err;

  modport slave (
    output ffs_vl_LP32ui_lp2sy_SoftReset_n, ffs_vl_LP32ui_lp2sy_InitDnForSys,
    input  ffs_vl61_LP32ui_sy2lp_C0TxHdr, ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    input  ffs_vl61_LP32ui_sy2lp_C1TxHdr, ffs_vl512_LP32ui_sy2lp_C1TxData,
    input  ffs_vl_LP32ui_sy2lp_C1TxWrValid, ffs_vl_LP32ui_sy2lp_C1TxIrValid,
    output ffs_vl_LP32ui_lp2sy_C0TxAlmFull, ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    output ffs_vl18_LP32ui_lp2sy_C0RxHdr, ffs_vl512_LP32ui_lp2sy_C0RxData,
    output ffs_vl_LP32ui_lp2sy_C0RxRdValid, ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    output ffs_vl_LP32ui_lp2sy_C0RxCgValid, ffs_vl_LP32ui_lp2sy_C0RxUgValid,
    output ffs_vl_LP32ui_lp2sy_C0RxIrValid,
    output ffs_vl18_LP32ui_lp2sy_C1RxHdr, ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    output ffs_vl_LP32ui_lp2sy_C1RxIrValid,
    output overflow_err
  );

  modport master (
    input  ffs_vl_LP32ui_lp2sy_SoftReset_n, ffs_vl_LP32ui_lp2sy_InitDnForSys,
    output ffs_vl61_LP32ui_sy2lp_C0TxHdr, ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    output ffs_vl61_LP32ui_sy2lp_C1TxHdr, ffs_vl512_LP32ui_sy2lp_C1TxData,
    output ffs_vl_LP32ui_sy2lp_C1TxWrValid, ffs_vl_LP32ui_sy2lp_C1TxIrValid,
    input  ffs_vl_LP32ui_lp2sy_C0TxAlmFull, ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    input  ffs_vl18_LP32ui_lp2sy_C0RxHdr, ffs_vl512_LP32ui_lp2sy_C0RxData,
    input  ffs_vl_LP32ui_lp2sy_C0RxRdValid, ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxCgValid, ffs_vl_LP32ui_lp2sy_C0RxUgValid,
    input  ffs_vl_LP32ui_lp2sy_C0RxIrValid,
    input  ffs_vl18_LP32ui_lp2sy_C1RxHdr, ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    input  ffs_vl_LP32ui_lp2sy_C1RxIrValid,
    input  overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/ccis_fiu_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ccis_fiu_mem_responder: loopback CCI-S FIU answering C0 reads / C1 writes from a local line memory.
// Revision 1.0
module ccis_fiu_mem_responder #(
  parameter int MEM_IDX_BITS  = 6,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 4,
  parameter int RSP_LATENCY   = 8,
  parameter int INIT_CYCLES   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  ccis_fiu_mem_responder_if.slave  cci
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int LINES  = 1 << MEM_IDX_BITS;

  localparam logic [CNT_W-1:0]  FULL_LVL    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ALMFULL_THR = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);
  localparam logic [14:0]       ELIG_AGE    = 15'(RSP_LATENCY - 1);
  localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYCLES - 2);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic              running;
  logic [14:0]       cyc;

  // ---------------- init FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RESET;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == ST_INIT) ? init_cnt + INIT_W'(1) : '0;
    end
  end

  // RESET lasts one cycle, so INIT ends two counts early to land RUN exactly INIT_CYCLES edges out.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT:  if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  logic almfull_c0, almfull_c1;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  always_comb begin
    running    = (state == ST_RUN);
    almfull_c0 = !running || (rd_cnt >= ALMFULL_THR);
    almfull_c1 = !running || (wr_cnt >= ALMFULL_THR);
  end

  always_ff @(posedge clk) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 15'd1;
  end

  // ---------------- request FIFOs ----------------
  logic [13:0]             rd_mdata_q [FIFO_DEPTH];
  logic [MEM_IDX_BITS-1:0] rd_idx_q   [FIFO_DEPTH];
  logic [14:0]             rd_stamp_q [FIFO_DEPTH];
  logic [13:0]             wr_mdata_q [FIFO_DEPTH];
  logic [MEM_IDX_BITS-1:0] wr_idx_q   [FIFO_DEPTH];
  logic [14:0]             wr_stamp_q [FIFO_DEPTH];
  logic [511:0]            wr_data_q  [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_wp, rd_rp, wr_wp, wr_rp;
  logic rd_req, wr_req, rd_push, wr_push, rd_pop, wr_pop;
  logic [14:0] rd_age, wr_age;

  // Full is judged on the registered count, so a pop in the same cycle never frees room for a push.
  assign rd_req  = running && cci.ffs_vl_LP32ui_sy2lp_C0TxRdValid;
  assign wr_req  = running && cci.ffs_vl_LP32ui_sy2lp_C1TxWrValid;
  assign rd_push = rd_req && (rd_cnt != FULL_LVL);
  assign wr_push = wr_req && (wr_cnt != FULL_LVL);
  assign rd_age  = cyc - rd_stamp_q[rd_rp];
  assign wr_age  = cyc - wr_stamp_q[wr_rp];
  assign rd_pop  = (rd_cnt != '0) && (rd_age >= ELIG_AGE);
  assign wr_pop  = (wr_cnt != '0) && (wr_age >= ELIG_AGE);

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mdata_q[rd_wp] <= cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[13:0];
      rd_idx_q[rd_wp]   <= cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[14 +: MEM_IDX_BITS];
      rd_stamp_q[rd_wp] <= cyc;
    end
    if (wr_push) begin
      wr_mdata_q[wr_wp] <= cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[13:0];
      wr_idx_q[wr_wp]   <= cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[14 +: MEM_IDX_BITS];
      wr_stamp_q[wr_wp] <= cyc;
      wr_data_q[wr_wp]  <= cci.ffs_vl512_LP32ui_sy2lp_C1TxData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wp  <= '0;
      rd_rp  <= '0;
      rd_cnt <= '0;
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_push) rd_wp <= rd_wp + PTR_W'(1);
      if (rd_pop)  rd_rp <= rd_rp + PTR_W'(1);
      if (wr_push) wr_wp <= wr_wp + PTR_W'(1);
      if (wr_pop)  wr_rp <= wr_rp + PTR_W'(1);
      rd_cnt <= rd_cnt + {{PTR_W{1'b0}}, rd_push} - {{PTR_W{1'b0}}, rd_pop};
      wr_cnt <= wr_cnt + {{PTR_W{1'b0}}, wr_push} - {{PTR_W{1'b0}}, wr_pop};
    end
  end

  // ---------------- line memory and responses ----------------
  logic [511:0] mem [LINES];
  logic [17:0]  c0_hdr, c1_hdr;
  logic [511:0] c0_data;
  logic         c0_valid, c1_valid, ovf;

  // Suppressing the write under reset keeps discarded requests from touching memory.
  always_ff @(posedge clk) begin
    if (wr_pop && !reset) mem[wr_idx_q[wr_rp]] <= wr_data_q[wr_rp];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c0_valid <= 1'b0;
      c0_hdr   <= '0;
      c0_data  <= '0;
      c1_valid <= 1'b0;
      c1_hdr   <= '0;
      ovf      <= 1'b0;
    end else begin
      c0_valid <= rd_pop;
      c1_valid <= wr_pop;
      if (rd_pop) begin
        c0_hdr  <= {4'h4, rd_mdata_q[rd_rp]};
        c0_data <= mem[rd_idx_q[rd_rp]];
      end
      if (wr_pop) c1_hdr <= {4'h1, wr_mdata_q[wr_rp]};
      if ((rd_req && !rd_push) || (wr_req && !wr_push)) ovf <= 1'b1;
    end
  end

  assign cci.ffs_vl_LP32ui_lp2sy_SoftReset_n  = running;
  assign cci.ffs_vl_LP32ui_lp2sy_InitDnForSys = running;
  assign cci.ffs_vl_LP32ui_lp2sy_C0TxAlmFull  = almfull_c0;
  assign cci.ffs_vl_LP32ui_lp2sy_C1TxAlmFull  = almfull_c1;
  assign cci.ffs_vl18_LP32ui_lp2sy_C0RxHdr    = c0_hdr;
  assign cci.ffs_vl512_LP32ui_lp2sy_C0RxData  = c0_data;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxRdValid  = c0_valid;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxWrValid  = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxCgValid  = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxUgValid  = 1'b0;
  assign cci.ffs_vl_LP32ui_lp2sy_C0RxIrValid  = 1'b0;
  assign cci.ffs_vl18_LP32ui_lp2sy_C1RxHdr    = c1_hdr;
  assign cci.ffs_vl_LP32ui_lp2sy_C1RxWrValid  = c1_valid;
  assign cci.ffs_vl_LP32ui_lp2sy_C1RxIrValid  = 1'b0;
  assign cci.overflow_err                     = ovf;

  // Interrupt requests and aliased address bits are intentionally dropped.
  logic unused_ok;
  assign unused_ok = &{1'b0, cci.ffs_vl_LP32ui_sy2lp_C1TxIrValid,
                       cci.ffs_vl61_LP32ui_sy2lp_C0TxHdr[60:14+MEM_IDX_BITS],
                       cci.ffs_vl61_LP32ui_sy2lp_C1TxHdr[60:14+MEM_IDX_BITS]};

endmodule
`default_nettype wire
